// File: rtl/c_pkg.sv
// Shared definitions for the CONV read-address generator: FSM encoding,
// config field widths and legal maxima.
package c_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned CFG_K_W = 3;
    localparam int unsigned CFG_S_W = 2;
    localparam int unsigned K_MAX   = 7;
    localparam int unsigned S_MAX   = 3;

endpackage

// File: rtl/c_raddr_gen_if.sv
// Address stream between c_raddr_gen (master) and the CONV read mux (slave).
interface c_raddr_gen_if #(
    parameter int unsigned AW = 14
) ();

    logic [AW-1:0] m_addr;
    logic          m_addr_first;
    logic          m_addr_last;
    logic          m_addr_valid;
    logic          m_addr_ready;

    modport master (
        output m_addr, m_addr_first, m_addr_last, m_addr_valid,
        input  m_addr_ready
    );

    modport slave (
        input  m_addr, m_addr_first, m_addr_last, m_addr_valid,
        output m_addr_ready
    );

endinterface

// File: rtl/c_win_cnt.sv
// Nested ky/kx window counter; exposes next-state position flags so the
// parent can register first/last alongside the address.
module c_win_cnt
    import c_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    input  logic [CFG_K_W-1:0] k,
    output logic [CFG_K_W-1:0] kx_nxt,
    output logic               kx_wrap,
    output logic               ky_wrap,
    output logic               first_nxt,
    output logic               last_nxt
);

    logic [CFG_K_W-1:0] kx_q, ky_q, ky_nxt, k_m1;

    assign k_m1    = k - CFG_K_W'(1);
    assign kx_wrap = (kx_q == k_m1);
    assign ky_wrap = (ky_q == k_m1);

    always_comb begin
        kx_nxt = kx_q;
        ky_nxt = ky_q;
        if (clr) begin
            kx_nxt = '0;
            ky_nxt = '0;
        end else if (step) begin
            if (kx_wrap) begin
                kx_nxt = '0;
                ky_nxt = ky_wrap ? '0 : ky_q + CFG_K_W'(1);
            end else begin
                kx_nxt = kx_q + CFG_K_W'(1);
            end
        end
        first_nxt = (kx_nxt == '0) && (ky_nxt == '0);
        last_nxt  = (kx_nxt == k_m1) && (ky_nxt == k_m1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_q <= '0;
            ky_q <= '0;
        end else begin
            kx_q <= kx_nxt;
            ky_q <= ky_nxt;
        end
    end

endmodule

// File: rtl/c_raddr_gen.sv
// Convolution read-address generator: walks every KxK window in raster order
// using only incremental adds and streams one word address per beat.
module c_raddr_gen
    import c_pkg::*;
#(
    parameter int unsigned AW  = 14,
    parameter int unsigned IFW = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AW-1:0]      cfg_base,
    input  logic [IFW-1:0]     cfg_w,
    input  logic [IFW-1:0]     cfg_h,
    input  logic [CFG_K_W-1:0] cfg_k,
    input  logic [CFG_S_W-1:0] cfg_s,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    c_raddr_gen_if.master      m
);

    localparam int unsigned CW = IFW + 2;

    state_e             state_q, state_d;
    logic [IFW-1:0]     w_q, w_d, h_q, h_d, col_q, col_d, rpos_q, rpos_d;
    logic [CFG_K_W-1:0] k_q, k_d, k_cur, kx_nxt;
    logic [CFG_S_W-1:0] s_q, s_d;
    logic [AW-1:0]      sw_q, sw_d, row_base_q, row_base_d, win_base_q, win_base_d;
    logic [AW-1:0]      row_ptr_q, row_ptr_d, addr_q, addr_d, cfg_w_ext;
    logic               first_q, first_d, last_q, last_d, valid_q, valid_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               clr, step, kx_wrap, ky_wrap, first_nxt, last_nxt;
    logic               cfg_ok, ox_adv, oy_adv, frame_end;

    c_win_cnt u_win_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .step      (step),
        .k         (k_cur),
        .kx_nxt    (kx_nxt),
        .kx_wrap   (kx_wrap),
        .ky_wrap   (ky_wrap),
        .first_nxt (first_nxt),
        .last_nxt  (last_nxt)
    );

    assign cfg_ok = (cfg_k != '0) && (cfg_s != '0) &&
                    (IFW'(cfg_k) <= cfg_w) && (IFW'(cfg_k) <= cfg_h);
    // Next window still fits when origin + S + K stays within the map edge.
    assign ox_adv = (CW'(col_q) + CW'(s_q) + CW'(k_q)) <= CW'(w_q);
    assign oy_adv = (CW'(rpos_q) + CW'(s_q) + CW'(k_q)) <= CW'(h_q);
    assign frame_end = kx_wrap && ky_wrap && !ox_adv && !oy_adv;
    assign cfg_w_ext = AW'(cfg_w);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        k_d        = k_q;
        s_d        = s_q;
        sw_d       = sw_q;
        col_d      = col_q;
        rpos_d     = rpos_q;
        row_base_d = row_base_q;
        win_base_d = win_base_q;
        row_ptr_d  = row_ptr_q;
        addr_d     = addr_q;
        first_d    = first_q;
        last_d     = last_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        clr        = 1'b0;
        step       = 1'b0;
        k_cur      = k_q;
        unique case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d    = RUN;
                    w_d        = cfg_w;
                    h_d        = cfg_h;
                    k_d        = cfg_k;
                    s_d        = cfg_s;
                    // S*W as up to three adds of W
                    sw_d       = cfg_w_ext + ((cfg_s >= 2'd2) ? cfg_w_ext : '0)
                                           + ((cfg_s == 2'd3) ? cfg_w_ext : '0);
                    col_d      = '0;
                    rpos_d     = '0;
                    row_base_d = cfg_base;
                    win_base_d = cfg_base;
                    row_ptr_d  = cfg_base;
                    clr        = 1'b1;
                    k_cur      = cfg_k;
                    addr_d     = cfg_base;
                    first_d    = 1'b1;
                    last_d     = last_nxt;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end else if (start) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && m.m_addr_ready) begin
                    if (frame_end) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (kx_wrap && ky_wrap && ox_adv) begin
                            col_d      = col_q + IFW'(s_q);
                            win_base_d = win_base_q + AW'(s_q);
                            row_ptr_d  = win_base_d;
                        end else if (kx_wrap && ky_wrap) begin
                            col_d      = '0;
                            rpos_d     = rpos_q + IFW'(s_q);
                            row_base_d = row_base_q + sw_q;
                            win_base_d = row_base_d;
                            row_ptr_d  = row_base_d;
                        end else if (kx_wrap) begin
                            row_ptr_d = row_ptr_q + AW'(w_q);
                        end
                        addr_d  = row_ptr_d + AW'(kx_nxt);
                        first_d = first_nxt;
                        last_d  = last_nxt;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            sw_q       <= '0;
            col_q      <= '0;
            rpos_q     <= '0;
            row_base_q <= '0;
            win_base_q <= '0;
            row_ptr_q  <= '0;
            addr_q     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            k_q        <= k_d;
            s_q        <= s_d;
            sw_q       <= sw_d;
            col_q      <= col_d;
            rpos_q     <= rpos_d;
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
            row_ptr_q  <= row_ptr_d;
            addr_q     <= addr_d;
            first_q    <= first_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign m.m_addr       = addr_q;
    assign m.m_addr_first = first_q;
    assign m.m_addr_last  = last_q;
    assign m.m_addr_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_c_raddr_gen.sv
// Bench for c_raddr_gen: a nested-loop window model feeds a per-cycle compare
// process; directed frames cover geometry, stalls, wrap, bad config and reset.
module tb_c_raddr_gen;
    import c_pkg::*;

    localparam int unsigned AW  = 14;
    localparam int unsigned IFW = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      cfg_base = '0;
    logic [IFW-1:0]     cfg_w = '0, cfg_h = '0;
    logic [CFG_K_W-1:0] cfg_k = '0;
    logic [CFG_S_W-1:0] cfg_s = '0;
    logic               busy, done, cfg_err;

    c_raddr_gen_if #(.AW(AW)) bus ();

    c_raddr_gen #(.AW(AW), .IFW(IFW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_w    (cfg_w),
        .cfg_h    (cfg_h),
        .cfg_k    (cfg_k),
        .cfg_s    (cfg_s),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .m        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_addr[$];
    bit exp_first[$];
    bit exp_last[$];
    int got_addr[$];
    int n_exp = 0;
    int idx = 0;
    bit active = 0, done_due = 0, started = 0, held = 0;
    int hold_addr;
    bit hold_first, hold_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: the four nested loops with plain multiplication.
    task automatic build(input int base, input int w, input int h, input int k, input int s);
        int ow, oh;
        exp_addr.delete();
        exp_first.delete();
        exp_last.delete();
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        exp_addr.push_back((base + (oy * s + ky) * w + ox * s + kx) % (1 << AW));
                        exp_first.push_back(ky == 0 && kx == 0);
                        exp_last.push_back(ky == k - 1 && kx == k - 1);
                    end
        n_exp = exp_addr.size();
    endtask

    initial forever begin
        @(negedge clk);
        if (active) begin
            if (done_due) begin
                chk("done_pulse", {31'd0, done}, 1);
                chk("valid_after_end", {31'd0, bus.m_addr_valid}, 0);
                chk("busy_after_end", {31'd0, busy}, 0);
                done_due = 0;
                active = 0;
            end else begin
                if (done) chk("early_done", {31'd0, done}, 0);
                if (bus.m_addr_valid) begin
                    started = 1;
                    if (held) begin
                        chk("stall_addr", 32'(bus.m_addr), hold_addr);
                        chk("stall_first", {31'd0, bus.m_addr_first}, {31'd0, hold_first});
                        chk("stall_last", {31'd0, bus.m_addr_last}, {31'd0, hold_last});
                    end
                    if (idx < n_exp) begin
                        chk($sformatf("addr[%0d]", idx), 32'(bus.m_addr), exp_addr[idx]);
                        chk($sformatf("first[%0d]", idx), {31'd0, bus.m_addr_first},
                            {31'd0, exp_first[idx]});
                        chk($sformatf("last[%0d]", idx), {31'd0, bus.m_addr_last},
                            {31'd0, exp_last[idx]});
                    end else begin
                        chk("beat_overrun", idx, n_exp - 1);
                    end
                    chk("busy_in_frame", {31'd0, busy}, 1);
                    if (bus.m_addr_ready) begin
                        got_addr.push_back(32'(bus.m_addr));
                        idx++;
                        held = 0;
                        if (idx == n_exp) done_due = 1;
                    end else begin
                        held = 1;
                        hold_addr = 32'(bus.m_addr);
                        hold_first = bus.m_addr_first;
                        hold_last = bus.m_addr_last;
                    end
                end else if (started) begin
                    chk("valid_drop", {31'd0, bus.m_addr_valid}, 1);
                end
            end
        end else if (bus.m_addr_valid) begin
            chk("stray_valid", {31'd0, bus.m_addr_valid}, 0);
        end
    end

    task automatic start_frame(input int base, input int w, input int h, input int k,
                               input int s);
        build(base, w, h, k, s);
        idx = 0;
        held = 0;
        done_due = 0;
        started = 0;
        got_addr.delete();
        @(posedge clk); #1;
        cfg_base = AW'(base);
        cfg_w = IFW'(w);
        cfg_h = IFW'(h);
        cfg_k = CFG_K_W'(k);
        cfg_s = CFG_S_W'(s);
        start = 1'b1;
        active = 1;
        @(posedge clk); #1;
        start = 1'b0;
        // Config changes after the start edge must not affect the frame.
        cfg_base = 14'd7;
        cfg_w = 7'd3;
        cfg_h = 7'd3;
        cfg_k = 3'd2;
        cfg_s = 2'd3;
        chk("first_valid", {31'd0, bus.m_addr_valid}, 1);
        chk("first_busy", {31'd0, busy}, 1);
    endtask

    task automatic finish_frame(input bit bp, input bit mid_start);
        for (int c = 0; c < 3000 && active; c++) begin
            bus.m_addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mid_start && c == 5) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.m_addr_ready = 1'b1;
        if (active) begin
            chk("frame_timeout", {31'd0, active}, 0);
            active = 0;
        end
        chk("beat_count", idx, n_exp);
        @(posedge clk); #1;
        chk("done_width", {31'd0, done}, 0);
    endtask

    task automatic illegal(input int w, input int h, input int k, input int s);
        @(posedge clk); #1;
        cfg_base = 14'd0;
        cfg_w = IFW'(w);
        cfg_h = IFW'(h);
        cfg_k = CFG_K_W'(k);
        cfg_s = CFG_S_W'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("cfg_err k%0d s%0d", k, s), {31'd0, cfg_err}, 1);
        chk("bad_cfg_done", {31'd0, done}, 1);
        chk("bad_cfg_busy", {31'd0, busy}, 0);
        chk("bad_cfg_valid", {31'd0, bus.m_addr_valid}, 0);
        @(posedge clk); #1;
        chk("cfg_err_width", {31'd0, cfg_err}, 0);
        chk("bad_cfg_busy2", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(bus.m_addr), 0);
        chk({tag, "_valid"}, {31'd0, bus.m_addr_valid}, 0);
        chk({tag, "_first"}, {31'd0, bus.m_addr_first}, 0);
        chk({tag, "_last"}, {31'd0, bus.m_addr_last}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_cfg_err"}, {31'd0, cfg_err}, 0);
    endtask

    int win0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    initial begin
        bus.m_addr_ready = 1'b1;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // W=4 H=4 K=3 S=1 base 0
        start_frame(0, 4, 4, 3, 1);
        finish_frame(0, 0);
        chk("t1_beats", got_addr.size(), 36);
        for (int i = 0; i < 9; i++) chk($sformatf("t1_win0[%0d]", i), got_addr[i], win0[i]);
        chk("t1_org1", got_addr[9], 1);
        chk("t1_org2", got_addr[18], 4);
        chk("t1_org3", got_addr[27], 5);
        chk("t1_model_first27", {31'd0, exp_first[27]}, 1);
        chk("t1_model_last35", {31'd0, exp_last[35]}, 1);

        // W=5 H=5 K=3 S=2 base 100
        start_frame(100, 5, 5, 3, 2);
        finish_frame(0, 0);
        chk("t2_beats", got_addr.size(), 36);
        chk("t2_org0", got_addr[0], 100);
        chk("t2_org1", got_addr[9], 102);
        chk("t2_org2", got_addr[18], 110);
        chk("t2_org3", got_addr[27], 112);

        // Same geometry as the first frame under random backpressure
        start_frame(0, 4, 4, 3, 1);
        finish_frame(1, 0);
        chk("bp_beats", got_addr.size(), 36);
        chk("bp_win0_last", got_addr[8], 10);

        // Address wrap at the top of the space, K=1
        start_frame((1 << AW) - 1, 2, 1, 1, 1);
        finish_frame(0, 0);
        chk("wrap_a0", got_addr[0], (1 << AW) - 1);
        chk("wrap_a1", got_addr[1], 0);

        illegal(4, 8, 5, 1);
        illegal(4, 4, 0, 1);
        illegal(4, 4, 3, 0);
        illegal(8, 2, 3, 1);

        // Reset mid-frame
        start_frame(0, 4, 4, 3, 1);
        repeat (10) @(posedge clk);
        #1;
        active = 0;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full frame after reset, with a start pulse during RUN
        start_frame(50, 6, 5, 2, 2);
        finish_frame(0, 1);
        chk("restart_beats", got_addr.size(), 3 * 2 * 4);
        chk("restart_org1", got_addr[4], 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c_raddr_gen.md
# c_raddr_gen

Convolution read-address generator for the CONV datapath. It sits directly upstream of the CONV read mux and drives its `m_addr` / `m_addr_first` / `m_addr_last` / `m_addr_valid` / `m_addr_ready` stream. Given a feature-map geometry, kernel size and stride, it walks every K×K input window in raster order and emits one word address per beat. `first` and `last` mark the window boundaries so downstream accumulators know where each output pixel starts and ends.

## Interface
- `AW`, 14, address width; all address arithmetic is modulo 2^AW.
- `IFW`, 7, width of the feature-map dimension fields.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; config is sampled on the same edge.
- `cfg_base`  in  AW  address of pixel (0,0).
- `cfg_w`  in  IFW  map width W, in words.
- `cfg_h`  in  IFW  map height H.
- `cfg_k`  in  3  kernel size K, valid range 1..7.
- `cfg_s`  in  2  stride S, valid range 1..3.
- `busy`  out  1  high from the first beat until the frame completes.
- `done`  out  1  one-cycle pulse after the frame's final beat is accepted.
- `cfg_err`  out  1  one-cycle pulse when config is illegal.
- `m_addr`  out  AW  read address.
- `m_addr_first`  out  1  first beat of a window (ky=kx=0).
- `m_addr_last`  out  1  last beat of a window (ky=kx=K-1).
- `m_addr_valid`  out  1  beat valid.
- `m_addr_ready`  in  1  downstream accept.

## Operation
- FSM states:
  - IDLE: `start` → check config. If legal → RUN; if illegal → pulse `cfg_err` and `done`, stay in IDLE.
  - RUN: emits beats. The transfer carrying the frame's last beat moves the FSM to IDLE and pulses `done`.
- Config legality:
  - Illegal if K=0, S=0, K>W or K>H.
  - Config is latched at `start`; input changes while in RUN are ignored.
- `start` while RUN: ignored. No queueing, no error.
- Loop order, outermost first: oy, ox, ky, kx.
  - Window origin column is `ox·S`. Advance ox while `ox·S+S+K ≤ W`.
  - oy uses the same rule against H.
- Beat address: `base + (oy·S+ky)·W + ox·S + kx`.
- Address generation is incremental only; no multipliers:
  - `win_base` register: +S per ox step; row restart adds `S·W`, computed as S repeated adds of W (S≤3, precomputed at start).
  - `row_ptr` register: starts at `win_base`, +W per ky step.
  - Address output: `row_ptr + kx`.
  - Each sum is truncated to AW bits, so wrap-around past 2^AW-1 to 0 is legal and required.
- Beats per frame: `Ow·Oh·K²`, where `Ow = (W-K)/S+1` and `Oh = (H-K)/S+1`.
- K=1: every beat has `first=last=1`.

## Timing
- Reset values:
  - FSM state IDLE.
  - All counters 0.
  - `m_addr` = 0, `m_addr_valid` = 0, `first` = 0, `last` = 0.
  - `busy` = 0, `done` = 0, `cfg_err` = 0.
- `start` sampled at edge T → first beat has `m_addr_valid=1` from T+1, with `busy=1`.
- Outputs are registered. Throughput is 1 beat/cycle while `m_addr_ready=1`.
- Valid/ready rules:
  - Transfer occurs on `valid&&ready`.
  - While `valid && !ready`, `addr`, `first` and `last` hold stable.
  - Valid never drops without a transfer.
- Final transfer at edge E:
  - `m_addr_valid=0`, `busy=0` and `done=1` from E+1.
  - `done` lasts 1 cycle.
  - A new `start` is accepted at E+1.
- Illegal config at edge T: `cfg_err=done=1` at T+1. No beats are issued and `busy` stays 0.
- `rst_n` asserted mid-frame: immediate return to reset values. No `done` pulse; the partial frame is abandoned.

## Structure
- Shared package `c_pkg` holds:
  - FSM state encoding (IDLE, RUN).
  - Field widths for `cfg_k` (3) and `cfg_s` (2).
  - Legal maxima constants K_MAX=7 and S_MAX=3.
- One natural sub-module: `c_win_cnt`, a nested ky/kx counter with wrap flags that drives `first`/`last` and the row steps.
- Everything else is flat.

## Test plan
- W=4, H=4, K=3, S=1, base=0, `ready` tied 1:
  - 36 beats.
  - Window 0 addresses: 0,1,2,4,5,6,8,9,10.
  - Window origins: 0,1,4,5.
  - `first` on beats 0,9,18,27; `last` on 8,17,26,35.
  - `done` one cycle after beat 35.
- W=5, H=5, K=3, S=2, base=100: window origins 100,102,110,112; 36 beats.
- Backpressure with a pseudo-random `ready` pattern at 50% duty: beat sequence identical to the ready=1 run, outputs stable during stalls, no lost or duplicated beats.
- K=1, S=1, W=2, H=1, base=2^AW-1:
  - Addresses 2^AW-1, then 0 (wrap).
  - Both beats have `first=last=1`.
- Illegal configs, one `start` each:
  - K=5 with W=4 → `cfg_err=done=1` one cycle later; zero beats; `busy` stays 0.
  - Repeat with K=0 and with S=0.
- Reset and restart:
  - Assert `rst_n` low mid-frame → all outputs 0 immediately.
  - After release, new `start` → a full correct frame.
  - `start` pulsed during RUN is ignored.
